wb_bram_ctrl: RTL
=================

# wb_bram_ctrl

Wishbone classic slave sitting directly upstream of the user-project block RAM. Decodes a fixed address window on the Caravel user Wishbone bus and converts each hit into a single-cycle BRAM access (port signals EN/WE/Di/A, 1-cycle registered read data). Inserts a programmable number of wait states before every access to model slow external memory. Returns read data and a one-cycle acknowledge.

## Interface
- BASE_ADDR, 32'h3800_0000, byte base address of the window
- ADDR_MASK, 32'hFFC0_0000, bits compared against BASE_ADDR for hit decode
- DELAYS, 10, wait-state cycles inserted before each BRAM access (0..255)
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte lane selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge, one cycle
- wbs_dat_o  out  32  read data, valid while ack high
- bram_en  out  1  BRAM enable
- bram_we  out  4  BRAM byte write enables
- bram_di  out  32  BRAM write data
- bram_a  out  32  BRAM word address
- bram_do  in  32  BRAM read data, valid the cycle after an enabled access

## Operation
- hit = cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR); non-hits ignored, no ack.
- States: IDLE, WAIT, ACCESS, READ, ACK.
- IDLE: on hit latch adr, dat, sel, we; go WAIT (DELAYS>0) or ACCESS (DELAYS=0); load counter with DELAYS-1.
- WAIT: counter decrements; at 0 go ACCESS. If cyc drops, go IDLE with no BRAM access and no ack.
- ACCESS: registered outputs bram_en=1, bram_we = we ? sel : 4'b0, bram_di = latched data, bram_a = (adr - BASE_ADDR) >> 2, zero-extended; go READ.
- READ: bram_en=0, bram_we=0; capture bram_do into wbs_dat_o register (reads only; writes leave wbs_dat_o unchanged); go ACK.
- ACK: wbs_ack_o=1 for exactly one cycle; go IDLE. Once ACCESS is reached the transfer always completes, even if cyc drops.
- Writes and reads follow the same state sequence and latency.
- Request still asserted in the IDLE cycle after ACK is treated as a new transfer (classic master deasserts stb after ack).
- Address arithmetic modulo 2^32; bits above window not checked beyond mask.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, bram_en=0, bram_we=0, bram_di=0, bram_a=0, state IDLE, counter 0.
- Request first seen in IDLE at cycle c0: WAIT c1..cDELAYS, ACCESS c(DELAYS+1), READ c(DELAYS+2), ACK c(DELAYS+3). Ack latency = DELAYS+3 cycles; DELAYS=10 gives 13.
- bram_en high exactly one cycle per transfer; never during WAIT, READ, ACK, IDLE.
- Reset asserted in any state: next cycle all outputs at reset values, state IDLE. Reset during ACCESS: the BRAM still commits at that edge (outputs already driven); no ack issued.
- Back-to-back transfers: minimum spacing DELAYS+4 cycles between ack pulses.

## Structure
- Package wb_bram_pkg: state encoding (3-bit), default BASE_ADDR/ADDR_MASK constants, DELAYS width constant (8 bits).
- One natural sub-module: wait_counter (load, decrement, zero flag); rest in a single FSM module.

## Test plan
- Reset: hold wb_rst_i 2 cycles mid-WAIT -> all outputs 0, state IDLE, no ack afterwards.
- Write 0xDEADBEEF, sel 4'hF, adr 0x3800_0010, DELAYS=10 -> bram_en/bram_we=4'hF/bram_a=4 in cycle 11 only, ack in cycle 13.
- Read back 0x3800_0010 with BRAM model -> wbs_dat_o=0xDEADBEEF during ack, ack at 13 cycles.
- Partial write sel 4'b0011 data 0x1234_5678 over 0xDEADBEEF -> bram_we=4'b0011; readback 0xDEAD5678.
- Access to 0x3000_0000 -> no bram_en, no ack for 40 cycles.
- DELAYS=0 build, cyc dropped during WAIT in DELAYS=10 build -> ack at 3 cycles; aborted transfer produces no bram_en and no ack.

Source files
------------

// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone-to-BRAM controller.
package wb_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_READ   = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFC0_0000;
  localparam int          DELAY_W       = 8;

  // Byte address inside the window converted to a BRAM word index (modulo 2^32).
  function automatic logic [31:0] word_addr(input logic [31:0] adr, input logic [31:0] base);
    return (adr - base) >> 2'd2;
  endfunction

endpackage

// File: rtl/wb_bram_ctrl_wait_counter.sv
// Wait-state down counter: loadable, decrements to zero and holds, zero flag out.
module wb_bram_ctrl_wait_counter
  import wb_bram_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [DELAY_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [DELAY_W-1:0] r_count;

  // Count register: load has priority over decrement, saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - {{(DELAY_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave turning window hits into single BRAM accesses after a
// programmable number of wait states; 1-cycle ack with registered read data.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int unsigned DELAYS    = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_di,
  output logic [31:0] bram_a,
  input  logic [31:0] bram_do
);

  localparam logic [DELAY_W-1:0] DELAYS_V = DELAYS[DELAY_W-1:0];
  localparam logic [DELAY_W-1:0] LOAD_V   = (DELAYS_V == 8'd0) ? 8'd0 : (DELAYS_V - 8'd1);

  state_t      r_state;
  state_t      w_next;
  logic        w_hit;
  logic        w_load;
  logic        w_zero;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        w_src_we;
  logic [3:0]  w_src_sel;
  logic [31:0] w_src_adr;
  logic [31:0] w_src_dat;
  logic        r_ack;
  logic [31:0] r_dat_o;
  logic        r_bram_en;
  logic [3:0]  r_bram_we;
  logic [31:0] r_bram_di;
  logic [31:0] r_bram_a;

  assign w_hit  = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_load = (r_state == ST_IDLE) & w_hit;

  // With zero wait states ACCESS is entered straight from IDLE, before the latch holds the request.
  assign w_src_we  = (r_state == ST_IDLE) ? wbs_we_i  : r_we;
  assign w_src_sel = (r_state == ST_IDLE) ? wbs_sel_i : r_sel;
  assign w_src_adr = (r_state == ST_IDLE) ? wbs_adr_i : r_adr;
  assign w_src_dat = (r_state == ST_IDLE) ? wbs_dat_i : r_dat;

  wb_bram_ctrl_wait_counter u_wait_counter (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_load     (w_load),
    .i_load_val (LOAD_V),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_zero)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_next = (DELAYS_V == 8'd0) ? ST_ACCESS : ST_WAIT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_zero) begin
          w_next = ST_ACCESS;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_ACCESS: w_next = ST_READ;
      ST_READ:   w_next = ST_ACK;
      ST_ACK:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request latch, captured once per accepted transfer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we  <= 1'b0;
      r_sel <= 4'h0;
      r_adr <= 32'h0;
      r_dat <= 32'h0;
    end else if (w_load) begin
      r_we  <= wbs_we_i;
      r_sel <= wbs_sel_i;
      r_adr <= wbs_adr_i;
      r_dat <= wbs_dat_i;
    end else begin
      r_we  <= r_we;
      r_sel <= r_sel;
      r_adr <= r_adr;
      r_dat <= r_dat;
    end
  end

  // Registered BRAM port and bus outputs, decoded from the state being entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_bram_en <= 1'b0;
      r_bram_we <= 4'h0;
      r_bram_di <= 32'h0;
      r_bram_a  <= 32'h0;
      r_ack     <= 1'b0;
      r_dat_o   <= 32'h0;
    end else begin
      r_bram_en <= (w_next == ST_ACCESS);
      r_ack     <= (w_next == ST_ACK);
      if (w_next == ST_ACCESS) begin
        r_bram_we <= w_src_we ? w_src_sel : 4'h0;
        r_bram_di <= w_src_dat;
        r_bram_a  <= word_addr(w_src_adr, BASE_ADDR);
      end else begin
        r_bram_we <= 4'h0;
        r_bram_di <= r_bram_di;
        r_bram_a  <= r_bram_a;
      end
      if ((r_state == ST_READ) && !r_we) begin
        r_dat_o <= bram_do;
      end else begin
        r_dat_o <= r_dat_o;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat_o;
  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_we;
  assign bram_di   = r_bram_di;
  assign bram_a    = r_bram_a;

endmodule
